// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bundle: decode-side handshake/payload, execute-side handshake/payload,
// flush and the load-use stall indication. master = surrounding pipeline, slave = stage.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4
) ();
    localparam int CTRL_W = 6 + ALUOP_W;

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [CTRL_W-1:0]       in_ctrl;
    logic [DATA_W-1:0]       in_pc4;
    logic [DATA_W-1:0]       in_rd1;
    logic [DATA_W-1:0]       in_rd2;
    logic [DATA_W-1:0]       in_imm;
    logic [3*REG_ADDR_W-1:0] in_regs;
    logic                    out_valid;
    logic                    out_ready;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [DATA_W-1:0]       out_pc4;
    logic [DATA_W-1:0]       out_rd1;
    logic [DATA_W-1:0]       out_rd2;
    logic [DATA_W-1:0]       out_imm;
    logic [REG_ADDR_W-1:0]   out_rs;
    logic [REG_ADDR_W-1:0]   out_rt;
    logic [REG_ADDR_W-1:0]   out_rd;
    logic                    hazard_stall;

    modport master (
        output flush, in_valid, in_ctrl, in_pc4, in_rd1, in_rd2, in_imm, in_regs, out_ready,
        input  in_ready, out_valid, out_ctrl, out_pc4, out_rd1, out_rd2, out_imm,
               out_rs, out_rt, out_rd, hazard_stall
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_pc4, in_rd1, in_rd2, in_imm, in_regs, out_ready,
        output in_ready, out_valid, out_ctrl, out_pc4, out_rd1, out_rd2, out_imm,
               out_rs, out_rt, out_rd, hazard_stall
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, 2-entry skid (output + skid reg),
// synchronous flush and control zero-masking. Optional load-use stall: ID_EX_HAZARD_EN.
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    id_ex_pipe_reg_if.slave bus
);
    localparam int CTRL_W      = 6 + ALUOP_W;
    localparam int MEMREAD_BIT = ALUOP_W + 2;
    localparam int PAY_W       = CTRL_W + 4 * DATA_W + 3 * REG_ADDR_W;

    logic [PAY_W-1:0] in_word_s;
    logic [PAY_W-1:0] o_data_q, o_data_d;
    logic [PAY_W-1:0] s_data_q, s_data_d;
    logic             o_valid_q, o_valid_d;
    logic             s_valid_q, s_valid_d;
    logic             acc_s;
    logic             drn_s;
    logic             hazard_s;

    assign in_word_s = {bus.in_ctrl, bus.in_pc4, bus.in_rd1, bus.in_rd2, bus.in_imm, bus.in_regs};

`ifdef ID_EX_HAZARD_EN
    logic [REG_ADDR_W-1:0] in_rs_s;
    logic [REG_ADDR_W-1:0] in_rt_s;

    assign in_rs_s = bus.in_regs[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign in_rt_s = bus.in_regs[2*REG_ADDR_W-1 -: REG_ADDR_W];

    // Load in execute whose destination feeds the instruction now in decode.
    always_comb begin
        hazard_s = o_valid_q & bus.out_ctrl[MEMREAD_BIT] & (bus.out_rt != {REG_ADDR_W{1'b0}})
                 & bus.in_valid & ((bus.out_rt == in_rs_s) | (bus.out_rt == in_rt_s));
    end
`else
    assign hazard_s = 1'b0;
`endif

    assign bus.in_ready     = ~s_valid_q & ~hazard_s;
    assign bus.hazard_stall = hazard_s;
    assign bus.out_valid    = o_valid_q;
    assign acc_s            = bus.in_valid & bus.in_ready;
    assign drn_s            = o_valid_q & bus.out_ready;

    // Ctrl field of the output register is kept zero whenever the slot is empty.
    assign {bus.out_ctrl, bus.out_pc4, bus.out_rd1, bus.out_rd2, bus.out_imm,
            bus.out_rs, bus.out_rt, bus.out_rd} = o_data_q;

    // Next-state of output and skid slots; flush overrides everything else.
    always_comb begin
        o_data_d  = o_data_q;
        s_data_d  = s_data_q;
        o_valid_d = o_valid_q;
        s_valid_d = s_valid_q;
        if (bus.flush) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!o_valid_q || drn_s) begin
            if (s_valid_q) begin
                o_data_d  = s_data_q;
                o_valid_d = 1'b1;
                s_valid_d = 1'b0;
                if (acc_s) begin
                    s_data_d  = in_word_s;
                    s_valid_d = 1'b1;
                end else begin
                    s_valid_d = 1'b0;
                end
            end else if (acc_s) begin
                o_data_d  = in_word_s;
                o_valid_d = 1'b1;
            end else begin
                o_valid_d = 1'b0;
            end
        end else begin
            if (acc_s) begin
                s_data_d  = in_word_s;
                s_valid_d = 1'b1;
            end else begin
                s_valid_d = s_valid_q;
            end
        end
        if (!o_valid_d) begin
            o_data_d[PAY_W-1 -: CTRL_W] = {CTRL_W{1'b0}};
        end else begin
            o_data_d[PAY_W-1 -: CTRL_W] = o_data_d[PAY_W-1 -: CTRL_W];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data_q  <= {PAY_W{1'b0}};
            s_data_q  <= {PAY_W{1'b0}};
            o_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            o_data_q  <= o_data_d;
            s_data_q  <= s_data_d;
            o_valid_q <= o_valid_d;
            s_valid_q <= s_valid_d;
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus random traffic
// checked against an in-order queue model of the two-entry stage.
module tb_id_ex_pipe_reg;
    typedef struct packed {
        logic [9:0]  ctrl;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } word_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    word_t exp_q[$];

    id_ex_pipe_reg_if bus ();

    id_ex_pipe_reg dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic word_t rand_word();
        word_t w;
        w.ctrl = 10'($urandom);
        w.pc4  = $urandom;
        w.rd1  = $urandom;
        w.rd2  = $urandom;
        w.imm  = $urandom;
        w.rs   = 5'($urandom_range(0, 7));
        w.rt   = 5'($urandom_range(0, 7));
        w.rd   = 5'($urandom_range(0, 31));
        return w;
    endfunction

    function automatic word_t out_word();
        return {bus.out_ctrl, bus.out_pc4, bus.out_rd1, bus.out_rd2, bus.out_imm,
                bus.out_rs, bus.out_rt, bus.out_rd};
    endfunction

    function automatic bit model_hazard();
`ifdef ID_EX_HAZARD_EN
        if (exp_q.size() == 0) return 1'b0;
        return exp_q[0].ctrl[6] && (exp_q[0].rt != 5'd0) && bus.in_valid &&
               ((exp_q[0].rt == bus.in_regs[14:10]) || (exp_q[0].rt == bus.in_regs[9:5]));
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        return (exp_q.size() < 2) && !model_hazard();
    endfunction

    task automatic drive(input bit v, input word_t w, input bit ordy, input bit fl);
        bus.in_valid  = v;
        bus.in_ctrl   = w.ctrl;
        bus.in_pc4    = w.pc4;
        bus.in_rd1    = w.rd1;
        bus.in_rd2    = w.rd2;
        bus.in_imm    = w.imm;
        bus.in_regs   = {w.rs, w.rt, w.rd};
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    // Advance one clock and update the reference queue from the inputs seen at the edge.
    task automatic tick();
        bit    acc;
        bit    drn;
        bit    fl;
        word_t w;
        acc = bus.in_valid && model_ready();
        drn = (exp_q.size() > 0) && bus.out_ready;
        fl  = bus.flush;
        w   = {bus.in_ctrl, bus.in_pc4, bus.in_rd1, bus.in_rd2, bus.in_imm, bus.in_regs};
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(w);
        end
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || out_word() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b word=%h, want 0/0", bus.out_valid, out_word());
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", bus.in_ready);
        end
        drive(1'b1, rand_word(), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_valid: out_valid=%b want 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b out_ctrl=%h want 0/0", bus.out_valid, bus.out_ctrl);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_streaming();
        word_t w;
        for (int i = 1; i <= 3; i++) begin
            w = rand_word();
            w.ctrl[6] = 1'b0;
            w.pc4 = 32'(4 * i);
            drive(1'b1, w, 1'b1, 1'b0);
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: in_ready=%b want 1", i, bus.in_ready);
            end
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc4 !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: valid=%b pc4=%h want 1/%h", i, bus.out_valid, bus.out_pc4, 32'(4 * i));
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        word_t a, b, c;
        a = rand_word(); a.pc4 = 32'h100; a.ctrl[6] = 1'b0;
        b = rand_word(); b.pc4 = 32'h200; b.ctrl[6] = 1'b0;
        c = rand_word(); c.pc4 = 32'h300; c.ctrl[6] = 1'b0;
        drive(1'b1, a, 1'b0, 1'b0); tick();
        drive(1'b1, b, 1'b0, 1'b0); tick();
        drive(1'b1, c, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_pc4 !== 32'h100) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b pc4=%h want 0/100", bus.in_ready, bus.out_pc4);
        end
        tick();
        tick();
        n_checks++;
        if (bus.out_pc4 !== 32'h100 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: pc4=%h valid=%b in_ready=%b want 100/1/0", bus.out_pc4, bus.out_valid, bus.in_ready);
        end
        drive(1'b1, c, 1'b1, 1'b0); tick();
        n_checks++;
        if (bus.out_pc4 !== 32'h200 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: pc4=%h in_ready=%b want 200/1", bus.out_pc4, bus.in_ready);
        end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_pc4 !== 32'h300 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_third: pc4=%h valid=%b want 300/1", bus.out_pc4, bus.out_valid);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        word_t d;
        d = rand_word(); d.pc4 = 32'hDEAD;
        drive(1'b1, rand_word(), 1'b0, 1'b0); tick();
        drive(1'b1, rand_word(), 1'b0, 1'b0); tick();
        drive(1'b1, d, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'd0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: valid=%b ctrl=%h in_ready=%b want 0/0/1", bus.out_valid, bus.out_ctrl, bus.in_ready);
        end
        drive(1'b0, '0, 1'b1, 1'b0); tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_ghost: out_valid=%b pc4=%h want 0", bus.out_valid, bus.out_pc4);
        end
        drive(1'b1, rand_word(), 1'b0, 1'b0); tick();
        drive(1'b1, d, 1'b1, 1'b1); tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'd0) begin
            n_fail++;
            $display("FAIL flush_acc: valid=%b ctrl=%h want 0/0", bus.out_valid, bus.out_ctrl);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_acc_ghost: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_hazard();
        word_t lw, use_w;
        drain();
        lw = rand_word(); lw.ctrl[6] = 1'b1; lw.rt = 5'd5;
        use_w = rand_word(); use_w.rs = 5'd5; use_w.rt = 5'd1; use_w.pc4 = 32'h444; use_w.ctrl[6] = 1'b0;
        drive(1'b1, lw, 1'b0, 1'b0); tick();
        drive(1'b1, use_w, 1'b0, 1'b0);
        #1;
        n_checks++;
`ifdef ID_EX_HAZARD_EN
        if (bus.hazard_stall !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_stall: stall=%b in_ready=%b want 1/0", bus.hazard_stall, bus.in_ready);
        end
`else
        if (bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_off: stall=%b in_ready=%b want 0/1", bus.hazard_stall, bus.in_ready);
        end
`endif
        tick();
        drive(1'b1, use_w, 1'b1, 1'b0); tick();
        n_checks++;
        if (bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_clear: stall=%b in_ready=%b want 0/1", bus.hazard_stall, bus.in_ready);
        end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc4 !== 32'h444) begin
            n_fail++;
            $display("FAIL hazard_accept: valid=%b pc4=%h want 1/444", bus.out_valid, bus.out_pc4);
        end
        drain();
        lw.rt = 5'd0;
        use_w.rs = 5'd0; use_w.rt = 5'd0;
        drive(1'b1, lw, 1'b0, 1'b0); tick();
        drive(1'b1, use_w, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_r0: stall=%b in_ready=%b want 0/1", bus.hazard_stall, bus.in_ready);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, rand_word(), ($urandom % 3) != 0, ($urandom % 25) == 0);
            #1;
            n_checks++;
            if (bus.in_ready !== model_ready() || bus.hazard_stall !== model_hazard()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: in_ready=%b stall=%b want %b/%b", i, bus.in_ready,
                         bus.hazard_stall, model_ready(), model_hazard());
            end
            tick();
            n_checks++;
            if (bus.out_valid !== (exp_q.size() > 0)) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: out_valid=%b want %b", i, bus.out_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && out_word() !== exp_q[0]) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got %h want %h", i, out_word(), exp_q[0]);
            end else if (exp_q.size() == 0 && bus.out_ctrl !== 10'd0) begin
                n_fail++;
                $display("FAIL rand_mask[%0d]: out_ctrl=%h want 0", i, bus.out_ctrl);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_hazard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
